product_shift_register: RTL and testbench

PRODUCT_SHIFT_REGISTER -- requirements
Module: product_shift_register

---
 rtl/product_shift_register.sv | 97 +++++++++
 tb/tb_product_shift_register.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/product_shift_register.sv
// product_shift_register
//
// Product register for a sequential shift-add multiplier, and a plain
// serial-in right shift register.
//   Mode 00 hold, 01 parallel load, 10 add-step, 11 shift.
//   An add-step writes the adder sum into the upper half. The adder carry
//   goes into the MSB. The lower half (the multiplier) shifts right by one.
//   After HALF steps, Done sets and further steps are ignored until the
//   next load or reset.
//
// Ports
//   Clk       clock, rising edge
//   Reset     synchronous, active-high
//   En        global enable, 0 holds all state
//   Mode[1:0] operation select
//   In        parallel load value (WIDTH)
//   Upper     adder sum for add-step (HALF)
//   SerialIn  MSB fill bit (adder carry-out for add-step)
//   Out       register contents (registered)
//   Count     number of steps taken, saturates at HALF (registered)
//   Done      Count reached HALF (registered)
//   Zero      Out == 0, only with PRODUCT_SHIFT_REGISTER_ZERO_EN defined
//
// Optional feature macro: PRODUCT_SHIFT_REGISTER_ZERO_EN

module product_shift_register #(
    parameter int WIDTH = 64,
    parameter int HALF  = WIDTH / 2,
    localparam int CW   = $clog2(HALF + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic [1:0]       Mode,
    input  logic [WIDTH-1:0] In,
    input  logic [HALF-1:0]  Upper,
    input  logic             SerialIn,
    output logic [WIDTH-1:0] Out,
    output logic [CW-1:0]    Count,
`ifdef PRODUCT_SHIFT_REGISTER_ZERO_EN
    output logic             Done,
    output logic             Zero
`else
    output logic             Done
`endif
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LOAD  = 2'b01;
    localparam logic [1:0] MODE_ADD   = 2'b10;
    localparam logic [1:0] MODE_SHIFT = 2'b11;

    // Done is set on the edge where Count becomes HALF. That is the step
    // taken while Count still equals HALF-1.
    logic last_step;
    assign last_step = (Count == CW'(HALF - 1));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Out   <= '0;
            Count <= '0;
            Done  <= 1'b0;
        end else if (En) begin
            case (Mode)
                MODE_HOLD: ;
                MODE_LOAD: begin
                    Out   <= In;
                    Count <= '0;
                    Done  <= 1'b0;
                end
                MODE_ADD: begin
                    // Once Done is set, further steps are ignored. This keeps
                    // the product from shifting past its final position.
                    if (!Done) begin
                        Out   <= {SerialIn, Upper, Out[HALF-1:1]};
                        Count <= Count + CW'(1);
                        Done  <= last_step;
                    end
                end
                MODE_SHIFT: begin
                    if (!Done) begin
                        Out   <= {SerialIn, Out[WIDTH-1:1]};
                        Count <= Count + CW'(1);
                        Done  <= last_step;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PRODUCT_SHIFT_REGISTER_ZERO_EN
    // Decoded from the Out flops only, so no input reaches it combinationally.
    assign Zero = (Out == '0);
`endif

endmodule

// File: tb/tb_product_shift_register.sv
module tb_product_shift_register;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ---------------- WIDTH=8 instance ----------------
    logic       r8, e8, s8;
    logic [1:0] m8;
    logic [7:0] i8, o8;
    logic [3:0] u8;
    logic [2:0] c8;
    logic       d8;
`ifdef PRODUCT_SHIFT_REGISTER_ZERO_EN
    logic       z8;
`endif

    product_shift_register #(.WIDTH(8)) dut8 (
        .Clk(clk), .Reset(r8), .En(e8), .Mode(m8), .In(i8), .Upper(u8),
        .SerialIn(s8), .Out(o8), .Count(c8),
`ifdef PRODUCT_SHIFT_REGISTER_ZERO_EN
        .Done(d8), .Zero(z8)
`else
        .Done(d8)
`endif
    );

    // ---------------- WIDTH=64 instance ----------------
    logic        r64, e64, s64;
    logic [1:0]  m64;
    logic [63:0] i64, o64;
    logic [31:0] u64;
    logic [5:0]  c64;
    logic        d64;
`ifdef PRODUCT_SHIFT_REGISTER_ZERO_EN
    logic        z64;
`endif

    product_shift_register #(.WIDTH(64)) dut64 (
        .Clk(clk), .Reset(r64), .En(e64), .Mode(m64), .In(i64), .Upper(u64),
        .SerialIn(s64), .Out(o64), .Count(c64),
`ifdef PRODUCT_SHIFT_REGISTER_ZERO_EN
        .Done(d64), .Zero(z64)
`else
        .Done(d64)
`endif
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference model. The register is treated as an integer of w bits.
    // A step brings in a new top part and divides the part it keeps by two.
    function automatic void model(input int w, input bit rst, input bit en,
                                  input bit [1:0] mode, input bit [63:0] in,
                                  input bit [63:0] upper, input bit sin,
                                  input bit [63:0] o_in, input int c_in, input bit d_in,
                                  output bit [63:0] o, output int c, output bit d);
        int half = w / 2;
        bit [63:0] lowmask = (64'd1 << half) - 64'd1;
        bit [63:0] mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        o = o_in; c = c_in; d = d_in;
        if (rst) begin
            o = 0; c = 0; d = 0;
        end else if (en) begin
            if (mode == 2'd1) begin
                o = in & mask; c = 0; d = 0;
            end else if (mode != 2'd0 && !d_in) begin
                if (mode == 2'd2)
                    o = (64'(sin) << (w - 1)) | ((upper & lowmask) << (half - 1))
                        | ((o_in & lowmask) / 2);
                else
                    o = (64'(sin) << (w - 1)) | ((o_in & mask) / 2);
                c = c_in + 1;
                d = (c == half);
            end
        end
    endfunction

    typedef struct {
        bit       rst, en;
        bit [1:0] mode;
        bit [7:0] in;
        bit [3:0] upper;
        bit       sin;
        bit [7:0] eout;
        int       ecnt;
        bit       edone;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t v(bit rst, bit en, bit [1:0] mode, bit [7:0] in, bit [3:0] upper,
                               bit sin, bit [7:0] eout, int ecnt, bit edone);
        vec_t x;
        x.rst = rst; x.en = en; x.mode = mode; x.in = in; x.upper = upper; x.sin = sin;
        x.eout = eout; x.ecnt = ecnt; x.edone = edone;
        return x;
    endfunction

    bit [63:0] mo8, mo64, no;
    int        mc8, mc64, nc;
    bit        md8, md64, nd;

    initial begin
        r8 = 1; e8 = 0; m8 = 0; i8 = 0; u8 = 0; s8 = 0;
        r64 = 1; e64 = 0; m64 = 0; i64 = 0; u64 = 0; s64 = 0;

        // Fields: rst en mode in upper sin | out cnt done
        vt.push_back(v(1, 0, 3, 8'hFF, 0, 1, 8'h00, 0, 0)); // reset overrides En and Mode
        vt.push_back(v(0, 1, 1, 8'h80, 0, 0, 8'h80, 0, 0));
        vt.push_back(v(0, 1, 3, 8'h00, 0, 1, 8'hC0, 1, 0));
        vt.push_back(v(0, 1, 3, 8'h00, 0, 1, 8'hE0, 2, 0));
        vt.push_back(v(0, 1, 3, 8'h00, 0, 1, 8'hF0, 3, 0));
        vt.push_back(v(0, 1, 3, 8'h00, 0, 1, 8'hF8, 4, 1)); // Done on 4th
        vt.push_back(v(0, 1, 3, 8'h00, 0, 1, 8'hF8, 4, 1)); // 5th shift ignored
        vt.push_back(v(0, 1, 2, 8'h00, 4'hF, 1, 8'hF8, 4, 1)); // add ignored when Done
        vt.push_back(v(0, 1, 1, 8'h11, 0, 0, 8'h11, 0, 0)); // load clears Done
        vt.push_back(v(0, 1, 1, 8'hA5, 0, 0, 8'hA5, 0, 0));
        vt.push_back(v(0, 0, 3, 8'h00, 0, 1, 8'hA5, 0, 0)); // En=0 holds
        vt.push_back(v(0, 0, 3, 8'h00, 0, 1, 8'hA5, 0, 0));
        vt.push_back(v(0, 0, 3, 8'h00, 0, 1, 8'hA5, 0, 0));
        vt.push_back(v(0, 1, 0, 8'hFF, 0, 1, 8'hA5, 0, 0)); // Mode 00 holds
        vt.push_back(v(0, 1, 3, 8'h00, 0, 0, 8'h52, 1, 0));
        vt.push_back(v(0, 1, 3, 8'h00, 0, 1, 8'hA9, 2, 0));
        vt.push_back(v(1, 1, 3, 8'h00, 0, 1, 8'h00, 0, 0)); // reset mid-sequence
        vt.push_back(v(0, 1, 1, 8'h3C, 0, 0, 8'h3C, 0, 0));
        vt.push_back(v(0, 1, 2, 8'h00, 4'hA, 1, 8'hD6, 1, 0));
        vt.push_back(v(0, 1, 2, 8'h00, 4'h0, 0, 8'h03, 2, 0));
        vt.push_back(v(0, 1, 2, 8'h00, 4'h5, 0, 8'h29, 3, 0));
        vt.push_back(v(0, 1, 2, 8'h00, 4'hF, 1, 8'hFC, 4, 1));

        #1;
        foreach (vt[k]) begin
            r8 = vt[k].rst; e8 = vt[k].en; m8 = vt[k].mode;
            i8 = vt[k].in; u8 = vt[k].upper; s8 = vt[k].sin;
            @(posedge clk); #1;
            check($sformatf("vec%0d out", k), 64'(o8), 64'(vt[k].eout));
            check($sformatf("vec%0d count", k), 64'(c8), 64'(vt[k].ecnt));
            check($sformatf("vec%0d done", k), 64'(d8), 64'(vt[k].edone));
`ifdef PRODUCT_SHIFT_REGISTER_ZERO_EN
            check($sformatf("vec%0d zero", k), 64'(z8), 64'(vt[k].eout == 0));
`endif
        end

        // 32x32 shift-add multiply 0xD * 0xB on the 64-bit register.
        r64 = 1; e64 = 1; m64 = 3; i64 = '1;
        @(posedge clk); #1;
        check("w64 reset out", o64, 64'h0);
        check("w64 reset done", 64'(d64), 64'h0);
        r64 = 0; m64 = 1; i64 = 64'hD;
        @(posedge clk); #1;
        check("w64 load", o64, 64'hD);
        mo64 = 64'hD;
        for (int s = 0; s < 32; s++) begin
            bit [63:0] sum;
            sum = (mo64 >> 32) + (mo64[0] ? 64'hB : 64'h0);
            m64 = 2; u64 = sum[31:0]; s64 = sum[32];
            mo64 = (sum << 31) | ((mo64 & 64'hFFFF_FFFF) >> 1);
            @(posedge clk); #1;
            check($sformatf("mul step%0d out", s), o64, mo64);
            check($sformatf("mul step%0d count", s), 64'(c64), 64'(s + 1));
            check($sformatf("mul step%0d done", s), 64'(d64), 64'(s == 31));
        end
        check("mul product", o64, 64'h8F);
        m64 = 2; u64 = '1; s64 = 1;
        @(posedge clk); #1;
        check("mul extra step ignored", o64, 64'h8F);
        check("mul count held", 64'(c64), 64'd32);

        // Random stimulus on both widths against the model.
        mo8 = 0; mc8 = 0; md8 = 0; mo64 = 0; mc64 = 0; md64 = 0;
        r8 = 1; r64 = 1;
        @(posedge clk); #1;
        for (int n = 0; n < 400; n++) begin
            r8 = ($urandom_range(0, 39) == 0);
            e8 = ($urandom_range(0, 5) != 0);
            m8 = 2'($urandom_range(0, 3));
            if (m8 == 1 && $urandom_range(0, 3) != 0) m8 = 2'($urandom_range(2, 3));
            i8 = 8'($urandom); u8 = 4'($urandom); s8 = 1'($urandom);
            r64 = ($urandom_range(0, 79) == 0);
            e64 = ($urandom_range(0, 5) != 0);
            m64 = 2'($urandom_range(0, 3));
            if (m64 == 1 && $urandom_range(0, 7) != 0) m64 = 2'($urandom_range(2, 3));
            i64 = {$urandom, $urandom}; u64 = $urandom; s64 = 1'($urandom);
            model(8, r8, e8, m8, 64'(i8), 64'(u8), s8, mo8, mc8, md8, no, nc, nd);
            mo8 = no; mc8 = nc; md8 = nd;
            model(64, r64, e64, m64, i64, 64'(u64), s64, mo64, mc64, md64, no, nc, nd);
            mo64 = no; mc64 = nc; md64 = nd;
            @(posedge clk); #1;
            check($sformatf("rnd%0d w8 out", n), 64'(o8), mo8);
            check($sformatf("rnd%0d w8 count", n), 64'(c8), 64'(mc8));
            check($sformatf("rnd%0d w8 done", n), 64'(d8), 64'(md8));
            check($sformatf("rnd%0d w64 out", n), o64, mo64);
            check($sformatf("rnd%0d w64 count", n), 64'(c64), 64'(mc64));
            check($sformatf("rnd%0d w64 done", n), 64'(d64), 64'(md64));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
